// File: rtl/gate_truth_checker.sv
// Clocked sweep engine: drives every input vector into a single-output gate,
// samples its response after a settle interval and compares against TRUTH.
module gate_truth_checker #(
    parameter int unsigned                  N_IN   = 2,
    parameter logic [(1 << N_IN)-1:0]       TRUTH  = 4'b1000,
    parameter int unsigned                  SETTLE = 1,
    parameter int unsigned                  ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N_IN-1:0]  vec_out,
    input  logic             dut_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [N_IN-1:0]  first_err_vec
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_CHECK
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] settle_cnt;
    logic          mismatch;
    logic          last_vec;

    assign mismatch = (dut_in != TRUTH[vec_out]);
    assign last_vec = (vec_out == '1);
    assign pass     = done && (err_count == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: APPLY holds for SETTLE cycles, CHECK for one
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_APPLY;
            S_APPLY: if (settle_cnt == '0) state_nxt = S_CHECK;
            S_CHECK: state_nxt = last_vec ? S_IDLE : S_APPLY;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: vector stepping, settle timing, error accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_out         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
            settle_cnt      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        vec_out         <= '0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_vec   <= '0;
                        settle_cnt      <= SETTLE_LOAD;
                    end
                end
                S_APPLY: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        if (err_count != '1) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_vec   <= vec_out;
                        end
                    end
                    if (last_vec) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        vec_out    <= vec_out + 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
